// File: rtl/assembler_pkg.sv
// assembler_pkg: immediate kinds, immediate error codes and ASCII constants shared by the assembler blocks
package assembler_pkg;
    typedef enum logic [1:0] {
        I12  = 2'd0,
        U20  = 2'd1,
        RAW  = 2'd2,
        RSVD = 2'd3
    } imm_kind_t;
    typedef enum logic [1:0] {
        NO_QUOTE      = 2'd0,
        BAD_DIGIT     = 2'd1,
        EMPTY_OR_LONG = 2'd2,
        RANGE         = 2'd3
    } imm_err_t;
    localparam logic [7:0] ASCII_QUOTE = 8'h27;
endpackage

// File: rtl/immediate_sequencer_if.sv
// immediate_sequencer_if: request/result, line-buffer and interpreter signals of the immediate sequencer
//   slave  : the sequencer (drives address, interpreter controls, status and result)
//   master : encoder, line buffer and interpreter around it
interface immediate_sequencer_if #(
    parameter int ADDR_W = 8
);
    import assembler_pkg::*;
    logic              start_in;
    logic [ADDR_W-1:0] start_addr_in;
    imm_kind_t         imm_kind_in;
    logic [ADDR_W-1:0] char_addr_out;
    logic [7:0]        char_in;
    logic              interp_trigger_out;
    logic [7:0]        interp_ascii_out;
    logic              interp_rst_out;
    logic              interp_done_in;
    logic              interp_error_in;
    logic [31:0]       interp_imm_in;
    logic              busy_out;
    logic              imm_valid_out;
    logic [31:0]       imm_out;
    logic              err_out;
    imm_err_t          err_code_out;
    logic [ADDR_W-1:0] next_addr_out;
    modport slave (
        input  start_in, start_addr_in, imm_kind_in, char_in,
               interp_done_in, interp_error_in, interp_imm_in,
        output char_addr_out, interp_trigger_out, interp_ascii_out, interp_rst_out,
               busy_out, imm_valid_out, imm_out, err_out, err_code_out, next_addr_out
    );
    modport master (
        output start_in, start_addr_in, imm_kind_in, char_in,
               interp_done_in, interp_error_in, interp_imm_in,
        input  char_addr_out, interp_trigger_out, interp_ascii_out, interp_rst_out,
               busy_out, imm_valid_out, imm_out, err_out, err_code_out, next_addr_out
    );
endinterface

// File: rtl/immediate_sequencer_imm_range_check.sv
// immediate_sequencer_imm_range_check: range check and extension of an interpreted immediate
//   kind  : requested immediate kind
//   value : raw value from the interpreter
//   ok    : value fits the kind
//   ext   : value sign-extended from bit 11 for I12, unchanged otherwise
module immediate_sequencer_imm_range_check
    import assembler_pkg::*;
(
    input  imm_kind_t   kind,
    input  logic [31:0] value,
    output logic        ok,
    output logic [31:0] ext
);
    always_comb begin
        ok  = kind == I12 ? value <= 32'h0000_0FFF : kind == U20 ? value <= 32'h000F_FFFF : 1'b1;
        ext = kind == I12 ? {{20{value[11]}}, value[11:0]} : value;
    end
endmodule

// File: rtl/immediate_sequencer.sv
// immediate_sequencer: fetches a quoted hex immediate from the line buffer and drives the interpreter
//   clk_in   : clock
//   rst_n_in : asynchronous active-low reset
//   bus      : request/result, line-buffer read port and interpreter handshake (slave side)
module immediate_sequencer
    import assembler_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int MAX_DIGITS = 8
) (
    input logic                  clk_in,
    input logic                  rst_n_in,
    immediate_sequencer_if.slave bus
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_CHECK   = 3'd2;
    localparam logic [2:0] S_STREAM  = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_REPORT  = 3'd5;
    localparam logic [2:0] S_CLEANUP = 3'd6;

    logic [2:0]        state, nxt;
    logic [ADDR_W-1:0] addr, start_q;
    logic [CW-1:0]     cnt;
    imm_kind_t         kind_q;
    imm_err_t          fail_code;
    logic              ok_q, quote, stream_fail, enter_ok, enter_fail, rc_ok;
    logic [31:0]       rc_ext;

    immediate_sequencer_imm_range_check u_range (
        .kind  (kind_q),
        .value (bus.interp_imm_in),
        .ok    (rc_ok),
        .ext   (rc_ext)
    );

    // interpreter error outranks every character-based decision in STREAM and WAIT
    always_comb begin
        quote       = bus.char_in == ASCII_QUOTE;
        stream_fail = bus.interp_error_in || (quote ? cnt == '0 : cnt == CW'(MAX_DIGITS));
        enter_ok    = state == S_WAIT && !bus.interp_error_in && bus.interp_done_in && rc_ok;
        enter_fail  = (state == S_CHECK && !quote) || (state == S_STREAM && stream_fail) ||
                      (state == S_WAIT && (bus.interp_error_in || (bus.interp_done_in && !rc_ok)));
        fail_code   = state == S_CHECK ? NO_QUOTE : bus.interp_error_in ? BAD_DIGIT :
                      state == S_WAIT ? RANGE : EMPTY_OR_LONG;
        nxt = state;
        case (state)
            S_IDLE:   nxt = bus.start_in ? S_FETCH : S_IDLE;
            S_FETCH:  nxt = S_CHECK;
            S_CHECK:  nxt = enter_fail ? S_REPORT : S_STREAM;
            S_STREAM: nxt = enter_fail ? S_REPORT : quote ? S_WAIT : S_STREAM;
            S_WAIT:   nxt = enter_fail || enter_ok ? S_REPORT : S_WAIT;
            S_REPORT: nxt = ok_q ? S_IDLE : S_CLEANUP;
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state             <= S_IDLE;
            addr              <= '0;
            start_q           <= '0;
            cnt               <= '0;
            kind_q            <= I12;
            ok_q              <= 1'b0;
            bus.imm_out       <= '0;
            bus.err_code_out  <= NO_QUOTE;
            bus.next_addr_out <= '0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && bus.start_in) begin
                addr    <= bus.start_addr_in;
                start_q <= bus.start_addr_in;
                cnt     <= '0;
                kind_q  <= bus.imm_kind_in;
            end
            if (state inside {S_FETCH, S_CHECK, S_STREAM})
                addr <= addr + ADDR_W'(1);
            if (state == S_STREAM && !stream_fail && !quote)
                cnt <= cnt + CW'(1);
            // result registers are loaded on entry so they are valid throughout REPORT
            if (enter_ok || enter_fail) begin
                ok_q              <= enter_ok;
                bus.next_addr_out <= start_q + ADDR_W'(cnt) + ADDR_W'(2);
            end
            if (enter_ok)
                bus.imm_out <= rc_ext;
            if (enter_fail)
                bus.err_code_out <= fail_code;
        end
    end

    assign bus.char_addr_out      = addr;
    assign bus.interp_ascii_out   = bus.char_in;
    // only the first digit starts the interpreter; later digits are consumed by it unprompted
    assign bus.interp_trigger_out = state == S_STREAM && !bus.interp_error_in && !quote && cnt == '0;
    assign bus.interp_rst_out     = !rst_n_in || state == S_CLEANUP;
    assign bus.busy_out           = state != S_IDLE;
    assign bus.imm_valid_out      = state == S_REPORT && ok_q;
    assign bus.err_out            = state == S_REPORT && !ok_q;
endmodule

// File: tb/tb_immediate_sequencer.sv
// tb_immediate_sequencer: table, hand-written and random checks of immediate_sequencer against a scan model
module tb_immediate_sequencer;
    import assembler_pkg::*;

    typedef struct packed {
        bit          ok;
        logic [31:0] imm;
        logic [1:0]  code;
        int          cyc;
        logic [7:0]  nxt;
        int          trig;
    } res_t;
    typedef struct {
        string     txt;
        imm_kind_t k;
        res_t      e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    immediate_sequencer_if #(.ADDR_W(8)) bus ();
    immediate_sequencer #(.ADDR_W(8), .MAX_DIGITS(8)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    logic [7:0] mem [256];
    int   nvec, nmis;
    res_t got;
    logic [7:0] got_a1;
    int   got_rstc, got_rstcyc, got_pulses;
    vec_t tab [14];

    always @(posedge clk) bus.char_in <= mem[bus.char_addr_out];

    function automatic int hexv(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    // behavioural interpreter: triggered by the first digit, then eats one char per cycle until a quote
    logic i_act;
    always @(posedge clk) begin
        if (bus.interp_rst_out) begin
            i_act <= 1'b0;
            bus.interp_done_in <= 1'b0;
            bus.interp_error_in <= 1'b0;
            bus.interp_imm_in <= '0;
        end else if (bus.interp_trigger_out) begin
            bus.interp_done_in <= 1'b0;
            if (hexv(bus.interp_ascii_out) < 0) begin
                bus.interp_error_in <= 1'b1;
                i_act <= 1'b0;
            end else begin
                i_act <= 1'b1;
                bus.interp_imm_in <= 32'(hexv(bus.interp_ascii_out));
            end
        end else if (i_act) begin
            if (bus.interp_ascii_out == 8'h27) begin
                bus.interp_done_in <= 1'b1;
                i_act <= 1'b0;
            end else if (hexv(bus.interp_ascii_out) < 0) begin
                bus.interp_error_in <= 1'b1;
                i_act <= 1'b0;
            end else
                bus.interp_imm_in <= {bus.interp_imm_in[27:0], 4'(hexv(bus.interp_ascii_out))};
        end
    end

    // expected outcome from scanning the buffer text and counting cycles per the timing rules
    function automatic res_t ref_model(input logic [7:0] s, input imm_kind_t k);
        res_t r;
        longint v;
        logic [7:0] c;
        r = '0;
        if (mem[s] != 8'h27) begin
            r.code = 2'd0;
            r.cyc = 3;
            return r;
        end
        r.trig = mem[8'(s + 1)] != 8'h27 ? 1 : 0;
        v = 0;
        for (int i = 0; i <= 8; i++) begin
            c = mem[8'(s + 1 + i)];
            if (c == 8'h27) begin
                if (i == 0) begin
                    r.code = 2'd2;
                    r.cyc = 4;
                    return r;
                end
                r.cyc = i + 5;
                r.ok = k == I12 ? v <= 4095 : k == U20 ? v <= 1048575 : 1'b1;
                r.imm = (k == I12 && v >= 2048) ? 32'(v) + 32'hFFFF_F000 : 32'(v);
                r.nxt = 8'(s + i + 2);
                r.code = r.ok ? 2'd0 : 2'd3;
                if (!r.ok) r.imm = '0;
                return r;
            end
            if (i == 8) begin
                r.code = 2'd2;
                r.cyc = 12;
                return r;
            end
            if (hexv(c) < 0) begin
                r.code = 2'd1;
                r.cyc = i + 5;
                return r;
            end
            v = v * 16 + hexv(c);
        end
        return r;
    endfunction

    task automatic chk(input string n, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] s, input string t);
        for (int i = 0; i < 24; i++) mem[8'(s + i)] = 8'h20;
        for (int i = 0; i < t.len(); i++) mem[8'(s + i)] = t[i];
    endtask

    // called at a negedge in IDLE; returns at the negedge of the first IDLE cycle afterwards
    task automatic run_op(input logic [7:0] s, input imm_kind_t k, input int inject);
        int cyc;
        bit fin;
        got = '0;
        got_a1 = '0;
        got_rstc = 0;
        got_rstcyc = 0;
        got_pulses = 0;
        bus.start_in = 1'b1;
        bus.start_addr_in = s;
        bus.imm_kind_in = k;
        @(negedge clk);
        bus.start_in = 1'b0;
        cyc = 1;
        fin = 1'b0;
        while (!fin && cyc < 64) begin
            if (cyc == 1) got_a1 = bus.char_addr_out;
            if (bus.interp_trigger_out) got.trig++;
            if (bus.imm_valid_out) begin
                got.ok = 1'b1;
                got.imm = bus.imm_out;
                got.nxt = bus.next_addr_out;
                got.cyc = cyc;
                got_pulses++;
            end
            if (bus.err_out) begin
                got.code = bus.err_code_out;
                got.cyc = cyc;
                got_pulses++;
            end
            if (bus.interp_rst_out) begin
                got_rstc++;
                got_rstcyc = cyc;
            end
            if (cyc == inject) begin
                bus.start_in = 1'b1;
                bus.start_addr_in = s + 8'h30;
                bus.imm_kind_in = U20;
            end else
                bus.start_in = 1'b0;
            fin = !bus.busy_out;
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        bus.start_in = 1'b0;
        chk("op_finished", fin, 1);
    endtask

    task automatic check_op(input string tag, input logic [7:0] s, input res_t e);
        chk({tag, ".success"}, got.ok, e.ok);
        chk({tag, ".cycle"}, got.cyc, e.cyc);
        chk({tag, ".pulses"}, got_pulses, 1);
        chk({tag, ".fetch_addr"}, got_a1, s);
        chk({tag, ".triggers"}, got.trig, e.trig);
        chk({tag, ".interp_rsts"}, got_rstc, e.ok ? 0 : 1);
        if (e.ok) begin
            chk({tag, ".imm"}, got.imm, e.imm);
            chk({tag, ".next_addr"}, got.nxt, e.nxt);
        end else begin
            chk({tag, ".err_code"}, got.code, e.code);
            chk({tag, ".rst_cycle"}, got_rstcyc, e.cyc + 1);
        end
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, ".busy"}, bus.busy_out, 0);
        chk({tag, ".valid"}, bus.imm_valid_out, 0);
        chk({tag, ".err"}, bus.err_out, 0);
        chk({tag, ".trigger"}, bus.interp_trigger_out, 0);
        chk({tag, ".imm"}, bus.imm_out, 0);
        chk({tag, ".err_code"}, bus.err_code_out, 0);
        chk({tag, ".char_addr"}, bus.char_addr_out, 0);
        chk({tag, ".next_addr"}, bus.next_addr_out, 0);
        chk({tag, ".interp_rst"}, bus.interp_rst_out, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        string hx;
        logic [7:0] s;
        imm_kind_t k;
        int n;
        res_t e;
        nvec = 0;
        nmis = 0;
        hx = "0123456789ABCDEF";
        bus.start_in = 1'b0;
        bus.start_addr_in = '0;
        bus.imm_kind_in = I12;
        for (int i = 0; i < 256; i++) mem[i] = 8'h20;
        tab[0]  = '{"'7FF'",       I12,  '{1'b1, 32'h0000_07FF, 2'd0, 8,  8'h15, 1}};
        tab[1]  = '{"'800'",       I12,  '{1'b1, 32'hFFFF_F800, 2'd0, 8,  8'h15, 1}};
        tab[2]  = '{"'1000'",      I12,  '{1'b0, 32'h0,         2'd3, 9,  8'h00, 1}};
        tab[3]  = '{"'12G4'",      RAW,  '{1'b0, 32'h0,         2'd1, 7,  8'h00, 1}};
        tab[4]  = '{"'A'",         RAW,  '{1'b1, 32'h0000_000A, 2'd0, 6,  8'h13, 1}};
        tab[5]  = '{"'123456789'", RAW,  '{1'b0, 32'h0,         2'd2, 12, 8'h00, 1}};
        tab[6]  = '{"''",          RAW,  '{1'b0, 32'h0,         2'd2, 4,  8'h00, 0}};
        tab[7]  = '{"7F'",         RAW,  '{1'b0, 32'h0,         2'd0, 3,  8'h00, 0}};
        tab[8]  = '{"'FFFFF'",     U20,  '{1'b1, 32'h000F_FFFF, 2'd0, 10, 8'h17, 1}};
        tab[9]  = '{"'100000'",    U20,  '{1'b0, 32'h0,         2'd3, 11, 8'h00, 1}};
        tab[10] = '{"'FFFFFFFF'",  RAW,  '{1'b1, 32'hFFFF_FFFF, 2'd0, 13, 8'h1A, 1}};
        tab[11] = '{"'FFF'",       I12,  '{1'b1, 32'hFFFF_FFFF, 2'd0, 8,  8'h15, 1}};
        tab[12] = '{"'12345678'",  RSVD, '{1'b1, 32'h1234_5678, 2'd0, 13, 8'h1A, 1}};
        tab[13] = '{"'12G'",       RAW,  '{1'b0, 32'h0,         2'd1, 7,  8'h00, 1}};
        @(negedge clk);
        @(negedge clk);
        reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            load(8'h10, tab[i].txt);
            run_op(8'h10, tab[i].k, 0);
            check_op($sformatf("vec%0d", i), 8'h10, tab[i].e);
        end
        // start pulsed during STREAM must not change kind, address or restart the block
        load(8'h10, "'800'");
        run_op(8'h10, I12, 5);
        check_op("start_mid_stream", 8'h10, '{1'b1, 32'hFFFF_F800, 2'd0, 8, 8'h15, 1});
        @(negedge clk);
        chk("start_mid_stream.idle_after", bus.busy_out, 0);
        // asynchronous reset during STREAM
        load(8'h10, "'12345678'");
        bus.start_in = 1'b1;
        bus.start_addr_in = 8'h10;
        bus.imm_kind_in = RAW;
        @(negedge clk);
        bus.start_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset.busy", bus.busy_out, 1);
        #2 rst_n = 1'b0;
        #1 reset_vals("mid_reset");
        @(negedge clk);
        reset_vals("mid_reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset.interp_rst", bus.interp_rst_out, 0);
        load(8'h10, "'A'");
        run_op(8'h10, RAW, 0);
        check_op("post_reset", 8'h10, '{1'b1, 32'h0000_000A, 2'd0, 6, 8'h13, 1});
        // random texts, kinds and start addresses (some wrapping past 0xFF)
        for (int t = 0; t < 40; t++) begin
            s = (t % 5 == 0) ? 8'(8'hF8 + $urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            k = imm_kind_t'($urandom_range(0, 3));
            n = $urandom_range(0, 10);
            for (int j = 0; j < 16; j++) mem[8'(s + j)] = 8'h20;
            mem[s] = $urandom_range(0, 9) == 0 ? 8'h37 : 8'h27;
            for (int j = 0; j < n; j++)
                mem[8'(s + 1 + j)] = $urandom_range(0, 19) == 0 ? 8'h47 : hx[$urandom_range(0, 15)];
            mem[8'(s + 1 + n)] = 8'h27;
            e = ref_model(s, k);
            run_op(s, k, 0);
            check_op($sformatf("rnd%0d", t), s, e);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/immediate_sequencer.md
# immediate_sequencer

- Fetches a quote-delimited hex immediate field (e.g. `'7FF'`) from the assembler line buffer and streams its characters into one `immediate_interpreter` instance.
- Checks digit count and the value range for the requested immediate kind, and reports the result or a typed error.
- Recovers the interpreter after any error by resetting it.
- Sits between the line-buffer read port and the interpreter; the instruction encoder invokes it once per immediate operand.

## Interface
- `ADDR_W`, default 8: line-buffer address width.
- `MAX_DIGITS`, default 8: maximum hex digits accepted.
- `clk_in`, in, 1: clock. One clock domain.
- `rst_n_in`, in, 1: reset. Asynchronous, active-low.
- `start_in`, in, 1: single-cycle request. Honoured only in IDLE.
- `start_addr_in`, in, ADDR_W: address of the opening quote.
- `imm_kind_in`, in, 2: immediate kind (`imm_kind_t`). Sampled with `start_in`.
- `char_addr_out`, out, ADDR_W: line-buffer read address.
- `char_in`, in, 8: line-buffer data. Synchronous read, 1-cycle latency.
- `interp_trigger_out`, out, 1: trigger to the interpreter.
- `interp_ascii_out`, out, 8: character to the interpreter. Equals `char_in` (combinational).
- `interp_rst_out`, out, 1: active-high interpreter reset.
- `interp_done_in`, in, 1: interpreter done flag.
- `interp_error_in`, in, 1: interpreter error flag.
- `interp_imm_in`, in, 32: interpreter immediate value.
- `busy_out`, out, 1: high whenever state is not IDLE.
- `imm_valid_out`, out, 1: one-cycle pulse on success.
- `imm_out`, out, 32: result. Held until the next success.
- `err_out`, out, 1: one-cycle pulse on failure.
- `err_code_out`, out, 2: error code (`imm_err_t`). Held until the next error.
- `next_addr_out`, out, ADDR_W: address following the closing quote. Valid with `imm_valid_out`.

## Operation
- **States:** IDLE, FETCH, CHECK, STREAM, WAIT, REPORT, CLEANUP.
- **IDLE:**
  - On `start_in`: latch kind, load the address register with `start_addr_in`, clear the digit counter, go to FETCH.
  - `start_in` in any other state is ignored.
- **FETCH:** address increments; go to CHECK.
- **CHECK:**
  - Address increments.
  - If `char_in` ≠ `"'"`: error NO_QUOTE, go to REPORT.
  - Otherwise go to STREAM.
- **STREAM** (address increments every cycle):
  - `interp_error_in` high: error BAD_DIGIT. This takes priority over everything else.
  - `char_in` = `"'"` with count 0: error EMPTY_OR_LONG, with no trigger issued.
  - `char_in` = `"'"` with count > 0: go to WAIT.
  - Any other character: present it to the interpreter and increment the count.
    - `interp_trigger_out` is high only on the first such character (count 0).
    - If the count would exceed MAX_DIGITS: error EMPTY_OR_LONG (abort).
- **WAIT:**
  - `interp_error_in`: error BAD_DIGIT.
  - `interp_done_in`: apply the range check to `interp_imm_in`.
  - Neither: stay.
- **Range check:**
  - I12: value ≤ 0xFFF; `imm_out` = value sign-extended from bit 11.
  - U20: value ≤ 0xFFFFF; `imm_out` = value zero-extended.
  - RAW/RSVD: no check; `imm_out` = value.
  - Out of range: error RANGE.
- **REPORT:**
  - Pulse `imm_valid_out` or `err_out`.
  - `next_addr_out` = start + count + 2.
  - On success return to IDLE. On error go to CLEANUP.
- **CLEANUP:** `interp_rst_out` high for exactly one cycle, then IDLE.
- **Reset:**
  - While `rst_n_in` is low, `interp_rst_out` is high.
  - Asynchronous reset mid-operation forces IDLE with no pulse emitted.

## Timing
- **Reset values:**
  - state IDLE.
  - `busy_out`, `imm_valid_out`, `err_out`, `interp_trigger_out`: 0.
  - `imm_out`: 0. `err_code_out`: 0. `char_addr_out`: 0. `next_addr_out`: 0.
- **Cycle numbering:** start accepted at cycle 0.
  - Cycle 1 (FETCH): `char_addr_out` = start.
  - Cycle 2: opening quote checked.
  - Cycles 3..N+2: the N digits are streamed, one per cycle.
  - Cycle N+3: closing quote seen.
- **Success latency:**
  - Interpreter done is sampled in cycle N+4.
  - `imm_valid_out` pulses in cycle N+5.
- **Errors:**
  - NO_QUOTE: `err_out` in cycle 3.
  - BAD_DIGIT: `err_out` two cycles after the bad character is presented.
  - CLEANUP follows the error pulse on the next cycle.
- **Address wrap:** the address register wraps modulo 2^ADDR_W; no error.
- **Back-to-back:** a new `start_in` is accepted the cycle after `busy_out` falls.

## Structure
- **`assembler_pkg`** holds:
  - `imm_kind_t`: I12=0, U20=1, RAW=2, RSVD=3.
  - `imm_err_t`: NO_QUOTE=0, BAD_DIGIT=1, EMPTY_OR_LONG=2, RANGE=3.
  - Constant `ASCII_QUOTE` = 8'h27.
- **`_imm_range_check`** is one combinational sub-module: kind + 32-bit value → ok flag, extended value.
- The interpreter instance lives outside this block, in the operand path.

## Test plan
- The bench models the line buffer with 1-cycle read latency and instantiates `immediate_interpreter`. Each scenario uses start = 0x10.
- `'7FF'`, kind I12 → `imm_out` = 0x000007FF; `imm_valid_out` at cycle 8; `next_addr_out` = 0x15; no `interp_rst_out`.
- `'800'`, kind I12 → `imm_out` = 0xFFFFF800. `'1000'`, kind I12 → `err_out`, code RANGE, then a one-cycle `interp_rst_out`.
- `'12G4'`, kind RAW → BAD_DIGIT error, `interp_rst_out` pulse, return to IDLE. A following `'A'` succeeds with `imm_out` = 0xA.
- `'123456789'`, kind RAW → EMPTY_OR_LONG when the 9th digit arrives. `''` → EMPTY_OR_LONG with `interp_trigger_out` never asserted.
- `7F'` (no opening quote) → NO_QUOTE at cycle 3.
- `start_in` pulsed mid-STREAM → ignored.
- `rst_n_in` dropped mid-STREAM → immediate IDLE, all outputs at reset values, `interp_rst_out` high while in reset.
